// File: rtl/switch_egress_sink_if.sv
// Flit type and link/consumer bundle for the switch egress sink.
// The package holds the link-wide sizing so that the switch, the sink and the
// bench all agree on the flit layout.
package switch_egress_sink_pkg;
  localparam int NUM_VCS = 2;
  localparam int DEPTH   = 8;
  localparam int VC_W    = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1;

  typedef struct packed {
    logic [VC_W-1:0] vc;
    logic [3:0]      tag;
  } metadata_t;

  typedef struct packed {
    metadata_t   metadata;
    logic [31:0] payload;
  } flit_t;
endpackage

// Link side (switch -> sink flits, sink -> switch acks/credits) and the
// consumer valid/ready port. The sink uses the slave view.
interface switch_egress_sink_if;
  import switch_egress_sink_pkg::*;

  logic               data_ready_in;
  flit_t              in;
  logic               packet_sent;
  logic [NUM_VCS-1:0] credit_granted;
  logic               out_valid;
  flit_t              out_flit;
  logic [VC_W-1:0]    out_vc;
  logic               out_ready;
  logic               overflow_err;

  modport master (
    output data_ready_in, in, out_ready,
    input  packet_sent, credit_granted, out_valid, out_flit, out_vc, overflow_err
  );

  modport slave (
    input  data_ready_in, in, out_ready,
    output packet_sent, credit_granted, out_valid, out_flit, out_vc, overflow_err
  );
endinterface

// File: rtl/switch_egress_sink.sv
// Receive end of a switch output link.
// Flits land in per-VC FIFOs; each accepted flit is acked one cycle later and
// each slot freed by the consumer returns one credit one cycle later. The
// consumer side is a combinational round-robin pick over non-empty VCs that
// never looks at out_ready, so out_valid/out_flit/out_vc are stable per cycle.
module switch_egress_sink #(
  parameter int NUM_VCS = switch_egress_sink_pkg::NUM_VCS,
  parameter int DEPTH   = switch_egress_sink_pkg::DEPTH
) (
  input logic                 clk,
  input logic                 n_rst,
  switch_egress_sink_if.slave bus
);

  localparam int VC_W  = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef logic [VC_W-1:0] vc_t;
  typedef switch_egress_sink_pkg::flit_t flit_t;

  flit_t              r_mem   [NUM_VCS][DEPTH];
  logic [PTR_W-1:0]   r_wptr  [NUM_VCS];
  logic [PTR_W-1:0]   r_rptr  [NUM_VCS];
  logic [CNT_W-1:0]   r_count [NUM_VCS];
  vc_t                r_rr;
  logic               r_packet_sent;
  logic [NUM_VCS-1:0] r_credit;
  logic               r_overflow;

  vc_t                w_wr_vc;
  logic               w_vc_ok;
  logic               w_wr_full;
  logic               w_wr_ok;
  logic               w_wr_drop;
  logic               w_any;
  vc_t                w_sel;
  logic               w_pop;
  logic [NUM_VCS-1:0] w_wr_en;
  logic [NUM_VCS-1:0] w_pop_en;

  // Wrapping VC increment; NUM_VCS need not be a power of two.
  function automatic vc_t f_next_vc(input vc_t v);
    return (v == vc_t'(NUM_VCS - 1)) ? '0 : v + 1'b1;
  endfunction

  // Fullness is judged on the count before any same-cycle pop, so a sender
  // that ignores credits still sees a full FIFO as full.
  assign w_wr_vc   = bus.in.metadata.vc;
  assign w_vc_ok   = (int'(w_wr_vc) < NUM_VCS);
  assign w_wr_full = (r_count[w_wr_vc] == CNT_W'(DEPTH));
  assign w_wr_ok   = bus.data_ready_in && w_vc_ok && !w_wr_full;
  assign w_wr_drop = bus.data_ready_in && (!w_vc_ok || w_wr_full);

  // Round-robin pick: first non-empty VC at or after r_rr, wrapping.
  always_comb begin
    vc_t cand;
    w_any = 1'b0;
    w_sel = r_rr;
    cand  = r_rr;
    for (int i = 0; i < NUM_VCS; i++) begin
      if (!w_any && (r_count[cand] != '0)) begin
        w_any = 1'b1;
        w_sel = cand;
      end
      cand = f_next_vc(cand);
    end
  end

  assign w_pop = w_any && bus.out_ready;

  // Per-VC write and pop strobes.
  always_comb begin
    w_wr_en  = '0;
    w_pop_en = '0;
    for (int v = 0; v < NUM_VCS; v++) begin
      if (w_wr_ok && (w_wr_vc == vc_t'(v))) w_wr_en[v] = 1'b1;
      if (w_pop && (w_sel == vc_t'(v)))     w_pop_en[v] = 1'b1;
    end
  end

  // FIFO pointers and occupancy; write+pop on one VC leaves the count as is.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int v = 0; v < NUM_VCS; v++) begin
        r_wptr[v]  <= '0;
        r_rptr[v]  <= '0;
        r_count[v] <= '0;
      end
    end else begin
      for (int v = 0; v < NUM_VCS; v++) begin
        if (w_wr_en[v])  r_wptr[v] <= r_wptr[v] + 1'b1;
        if (w_pop_en[v]) r_rptr[v] <= r_rptr[v] + 1'b1;
        case ({w_wr_en[v], w_pop_en[v]})
          2'b10:   r_count[v] <= r_count[v] + 1'b1;
          2'b01:   r_count[v] <= r_count[v] - 1'b1;
          default: ;
        endcase
      end
    end
  end

  // Flit storage; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (w_wr_ok) r_mem[w_wr_vc][r_wptr[w_wr_vc]] <= bus.in;
  end

  // Arbiter pointer, ack/credit pulses and the sticky overflow flag.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_rr          <= '0;
      r_packet_sent <= 1'b0;
      r_credit      <= '0;
      r_overflow    <= 1'b0;
    end else begin
      if (w_pop) r_rr <= f_next_vc(w_sel);
      r_packet_sent <= w_wr_ok;
      r_credit      <= w_pop_en;
      if (w_wr_drop) r_overflow <= 1'b1;
    end
  end

  assign bus.out_valid      = w_any;
  assign bus.out_vc         = w_sel;
  assign bus.out_flit       = w_any ? r_mem[w_sel][r_rptr[w_sel]] : '0;
  assign bus.packet_sent    = r_packet_sent;
  assign bus.credit_granted = r_credit;
  assign bus.overflow_err   = r_overflow;

endmodule

// File: tb/tb_switch_egress_sink.sv
// Bench for switch_egress_sink: directed scenarios followed by randomized
// credit-respecting traffic. The driver keeps a queue-per-VC picture of what
// the sink should hold and queues the pops, acks and credits it expects; the
// monitor matches those against what the DUT actually shows.
module tb_switch_egress_sink;
  import switch_egress_sink_pkg::*;

  logic clk = 1'b0;
  logic n_rst = 1'b1;
  always #5 clk = ~clk;

  switch_egress_sink_if u_if();

  switch_egress_sink #(.NUM_VCS(NUM_VCS), .DEPTH(DEPTH)) u_dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (u_if)
  );

  typedef struct {
    int    cyc;
    int    vc;
    flit_t flit;
  } pop_exp_t;

  typedef struct {
    int                 cyc;
    logic [NUM_VCS-1:0] mask;
  } cred_exp_t;

  pop_exp_t  exp_pop[$];
  int        exp_ack[$];
  cred_exp_t exp_cred[$];
  flit_t     mq[NUM_VCS][$];
  int        rr = 0;
  int        ovf_from = -1;
  int        cyc = 0;
  int        n_cmp = 0;
  int        n_bad = 0;

  pop_exp_t  mon_pe;
  cred_exp_t mon_ce;
  int        mon_ac;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int model_sel();
    for (int i = 0; i < NUM_VCS; i++) begin
      int v;
      v = (rr + i) % NUM_VCS;
      if (mq[v].size() > 0) return v;
    end
    return -1;
  endfunction

  // Monitor: consumes expected events as the DUT presents them.
  initial begin
    forever begin
      @(negedge clk);
      if (u_if.out_valid && u_if.out_ready) begin
        check("pop_expected", exp_pop.size() != 0, 1);
        if (exp_pop.size() != 0) begin
          mon_pe = exp_pop.pop_front();
          check("pop_cycle", cyc, mon_pe.cyc);
          check("pop_vc", u_if.out_vc, mon_pe.vc);
          check("pop_flit", u_if.out_flit, mon_pe.flit);
        end
      end else if (exp_pop.size() != 0 && exp_pop[0].cyc <= cyc) begin
        mon_pe = exp_pop.pop_front();
        check("pop_handshake", u_if.out_valid && u_if.out_ready, 1);
      end

      if (u_if.packet_sent) begin
        check("ack_expected", exp_ack.size() != 0, 1);
        if (exp_ack.size() != 0) begin
          mon_ac = exp_ack.pop_front();
          check("ack_cycle", cyc, mon_ac);
        end
      end else if (exp_ack.size() != 0 && exp_ack[0] <= cyc) begin
        mon_ac = exp_ack.pop_front();
        check("ack_pulse", u_if.packet_sent, 1);
      end

      if (u_if.credit_granted != '0) begin
        check("cred_expected", exp_cred.size() != 0, 1);
        if (exp_cred.size() != 0) begin
          mon_ce = exp_cred.pop_front();
          check("cred_cycle", cyc, mon_ce.cyc);
          check("cred_mask", u_if.credit_granted, mon_ce.mask);
        end
      end else if (exp_cred.size() != 0 && exp_cred[0].cyc <= cyc) begin
        mon_ce = exp_cred.pop_front();
        check("cred_pulse", u_if.credit_granted, mon_ce.mask);
      end

      check("overflow_err", u_if.overflow_err, (ovf_from >= 0) && (cyc >= ovf_from));
    end
  end

  // One link cycle: check the presented head, drive inputs, and record what
  // the next edge must do.
  task automatic step(input bit wr, input int vc, input logic [31:0] pl, input bit rdy);
    int                 s;
    bit                 accepted;
    flit_t              f;
    pop_exp_t           pe;
    cred_exp_t          ce;
    s = model_sel();
    check("out_valid", u_if.out_valid, s >= 0);
    if (s >= 0) begin
      check("out_vc", u_if.out_vc, s);
      check("out_flit", u_if.out_flit, mq[s][0]);
    end
    f.metadata.vc  = VC_W'(vc);
    f.metadata.tag = 4'($urandom);
    f.payload      = pl;
    u_if.data_ready_in = wr;
    u_if.in            = f;
    u_if.out_ready     = rdy;
    accepted = 1'b0;
    if (wr) begin
      if (mq[vc].size() >= DEPTH) begin
        if (ovf_from < 0) ovf_from = cyc + 1;
      end else begin
        accepted = 1'b1;
        exp_ack.push_back(cyc + 1);
      end
    end
    if (rdy && s >= 0) begin
      pe.cyc  = cyc;
      pe.vc   = s;
      pe.flit = mq[s][0];
      exp_pop.push_back(pe);
      void'(mq[s].pop_front());
      rr = (s + 1) % NUM_VCS;
      ce.cyc  = cyc + 1;
      ce.mask = '0;
      ce.mask[s] = 1'b1;
      exp_cred.push_back(ce);
    end
    if (accepted) mq[vc].push_back(f);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    u_if.data_ready_in = 1'b0;
    u_if.out_ready     = 1'b0;
    n_rst              = 1'b0;
    exp_pop.delete();
    exp_ack.delete();
    exp_cred.delete();
    for (int v = 0; v < NUM_VCS; v++) mq[v].delete();
    rr       = 0;
    ovf_from = -1;
    @(negedge clk);
    #1;
    check("rst_out_valid", u_if.out_valid, 0);
    check("rst_packet_sent", u_if.packet_sent, 0);
    check("rst_credit", u_if.credit_granted, 0);
    check("rst_overflow", u_if.overflow_err, 0);
    check("rst_out_flit", u_if.out_flit, 0);
    @(posedge clk);
    #1;
    n_rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int vc;
    bit wr;
    bit rdy;
    u_if.data_ready_in = 1'b0;
    u_if.in            = '0;
    u_if.out_ready     = 1'b0;
    #2;
    do_reset();
    step(0, 0, 32'h0, 0);

    // Single VC0 flit straight through to the consumer.
    step(1, 0, 32'hA5A5_0001, 1);
    step(0, 0, 32'h0, 1);
    step(0, 0, 32'h0, 1);
    step(0, 0, 32'h0, 0);

    // Fill VC1 with the consumer stalled, then one write too many.
    for (int i = 0; i < DEPTH + 1; i++) step(1, 1, $urandom, 0);
    step(0, 0, 32'h0, 0);
    step(0, 0, 32'h0, 0);

    // Reset in the middle of traffic, then a fresh write.
    step(1, 0, $urandom, 1);
    step(1, 0, $urandom, 1);
    do_reset();
    step(1, 1, 32'h0000_5107, 0);
    step(0, 0, 32'h0, 1);
    step(0, 0, 32'h0, 0);

    // Three flits on each VC, then drain round-robin.
    for (int i = 0; i < 3; i++) begin
      step(1, 0, $urandom, 0);
      step(1, 1, $urandom, 0);
    end
    for (int i = 0; i < 8; i++) step(0, 0, 32'h0, 1);

    // Same-cycle pop and write on a VC holding one flit.
    step(1, 0, 32'h0000_AAA1, 0);
    step(1, 0, 32'h0000_AAA2, 1);
    step(0, 0, 32'h0, 0);
    step(0, 0, 32'h0, 1);
    step(0, 0, 32'h0, 0);

    // Continuous VC0 stream across several pointer wraps.
    for (int i = 0; i < 20; i++) step(1, 0, $urandom, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 32'h0, 1);

    // Randomized credit-respecting traffic with one reset in the middle.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset();
      vc  = $urandom_range(0, NUM_VCS - 1);
      wr  = ($urandom_range(0, 3) != 0) && (mq[vc].size() < DEPTH);
      rdy = ($urandom_range(0, 2) != 0);
      step(wr, vc, $urandom, rdy);
    end

    for (int i = 0; i < 4 * DEPTH * NUM_VCS; i++) step(0, 0, 32'h0, 1);
    step(0, 0, 32'h0, 0);
    step(0, 0, 32'h0, 0);

    check("left_pops", exp_pop.size(), 0);
    check("left_acks", exp_ack.size(), 0);
    check("left_creds", exp_cred.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
